// File: rtl/count_if_pkg.sv
// Shared definitions for the count/status strobe interface of the two-bit
// event counter. The issuer and the downstream counter both import this.
package count_if_pkg;

  // Issuer control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_CLEAR = 2'd3
  } issuer_state_t;

  // Encodings driven on the count strobe.
  localparam logic [1:0] COUNT_INC  = 2'b01;
  localparam logic [1:0] COUNT_IDLE = 2'b00;

endpackage : count_if_pkg

// File: rtl/gap_timer.sv
// Loadable down-counter that times the idle spacing between increment pulses.
// Ports:
//   i_clk     - clock, posedge
//   i_rst     - synchronous active-high reset
//   i_load    - reload with GAP-1 so the caller spends exactly GAP cycles waiting
//   o_expired - count has reached zero
module gap_timer #(
  parameter int unsigned GAP = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int unsigned TW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(GAP - 1);

  logic [TW-1:0] r_cnt;

  // Down-count, saturating at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule : gap_timer

// File: rtl/count_issuer.sv
// Converts increment requests into spaced count=01 pulses, issues status clear
// pulses, and keeps a shadow copy of the downstream counter value.
// Ports:
//   i_clk, i_rst       - clock and synchronous active-high reset
//   i_req_valid        - increment request present
//   o_req_ready        - request accepted when valid && ready (combinational)
//   i_req_len          - number of increments in the request
//   i_clr_req          - level request to clear the downstream counter
//   o_count            - increment strobe (COUNT_INC / COUNT_IDLE)
//   o_status           - one-cycle clear strobe
//   o_shadow           - expected downstream counter value
//   o_busy             - issuer is not idle
//   o_done             - one-cycle pulse when a request completes
module count_issuer
  import count_if_pkg::*;
#(
  parameter int unsigned W    = 2,
  parameter int unsigned LW   = 4,
  parameter int unsigned GAP  = 1,
  parameter int unsigned TERM = (1 << W) - 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [LW-1:0] i_req_len,
  input  logic          i_clr_req,
  output logic [1:0]    o_count,
  output logic          o_status,
  output logic [W-1:0]  o_shadow,
  output logic          o_busy,
  output logic          o_done
);

  issuer_state_t r_state, w_state_nxt;

  logic [W-1:0]  r_shadow, w_shadow_nxt, w_shadow_inc;
  logic [LW-1:0] r_rem, w_rem_nxt, w_rem_dec;
  logic          r_in_req, w_in_req_nxt;
  logic          r_clr_pend, w_clr_pend_nxt;
  logic [1:0]    r_count, w_count_nxt;
  logic          r_status, w_status_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          w_gap_load;
  logic          w_gap_expired;

  // Clear requests (live or pending) block new requests.
  assign o_req_ready = !i_rst && (r_state == S_IDLE) && !i_clr_req && !r_clr_pend;

  assign w_shadow_inc = r_shadow + W'(1);
  assign w_rem_dec    = r_rem - LW'(1);

  // Next-state and next-output logic; strobes are registered from the next state
  // so they line up with the cycle the state is entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_shadow_nxt   = r_shadow;
    w_rem_nxt      = r_rem;
    w_in_req_nxt   = r_in_req;
    w_clr_pend_nxt = r_clr_pend | (i_clr_req && (r_state != S_IDLE));
    w_done_nxt     = 1'b0;
    w_gap_load     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_clr_req || r_clr_pend) begin
          w_state_nxt = S_CLEAR;
        end else if (i_req_valid) begin
          if (i_req_len != '0) begin
            w_rem_nxt    = i_req_len;
            w_in_req_nxt = 1'b1;
            w_state_nxt  = S_PULSE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end

      S_PULSE: begin
        w_shadow_nxt = w_shadow_inc;
        w_rem_nxt    = w_rem_dec;
        if (w_shadow_inc == W'(TERM)) begin
          w_state_nxt = S_CLEAR;
        end else if (w_rem_dec == '0) begin
          w_state_nxt  = S_IDLE;
          w_done_nxt   = 1'b1;
          w_in_req_nxt = 1'b0;
        end else if (GAP == 0) begin
          w_state_nxt = S_PULSE;
        end else begin
          w_state_nxt = S_GAP;
          w_gap_load  = 1'b1;
        end
      end

      S_GAP: begin
        if (w_gap_expired) begin
          w_state_nxt = S_PULSE;
        end
      end

      S_CLEAR: begin
        w_shadow_nxt   = '0;
        w_clr_pend_nxt = 1'b0;
        if (r_rem != '0) begin
          if (GAP == 0) begin
            w_state_nxt = S_PULSE;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_load  = 1'b1;
          end
        end else begin
          // Done only when this clear finished a request (auto-clear on last pulse).
          w_state_nxt  = S_IDLE;
          w_done_nxt   = r_in_req;
          w_in_req_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_count_nxt  = (w_state_nxt == S_PULSE) ? COUNT_INC : COUNT_IDLE;
    w_status_nxt = (w_state_nxt == S_CLEAR);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_shadow   <= '0;
      r_rem      <= '0;
      r_in_req   <= 1'b0;
      r_clr_pend <= 1'b0;
      r_count    <= COUNT_IDLE;
      r_status   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shadow   <= w_shadow_nxt;
      r_rem      <= w_rem_nxt;
      r_in_req   <= w_in_req_nxt;
      r_clr_pend <= w_clr_pend_nxt;
      r_count    <= w_count_nxt;
      r_status   <= w_status_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Spacing timer exists only when pulses are not back-to-back.
  generate
    if (GAP > 0) begin : g_gap
      gap_timer #(
        .GAP(GAP)
      ) u_gap_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_gap_load),
        .o_expired(w_gap_expired)
      );
    end else begin : g_no_gap
      logic w_unused_gap_load;
      assign w_unused_gap_load = w_gap_load;
      assign w_gap_expired     = 1'b1;
    end
  endgenerate

  assign o_count  = r_count;
  assign o_status = r_status;
  assign o_shadow = r_shadow;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule : count_issuer
